// File: rtl/formula_sum_isqrt_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// formula_sum_isqrt_pkg - state encoding and width helpers.     Rev 1.0
// ---------------------------------------------------------------------------
package formula_sum_isqrt_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Index into a batch; kept at least one bit wide so N_ARGS=1 still elaborates.
  function automatic int idx_width(input int n_args);
    return (n_args > 1) ? $clog2(n_args) : 1;
  endfunction

  function automatic int cnt_width(input int max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

  function automatic bit res_w_legal(input int res_w, input int w, input int n_args);
    return res_w >= (w / 2 + $clog2(n_args));
  endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_result_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// isqrt_result_accumulator - tracks in-flight isqrt ops, sums each batch.  Rev 1.0
// ---------------------------------------------------------------------------
module isqrt_result_accumulator
  import formula_sum_isqrt_pkg::*;
#(
  parameter int N_ARGS       = 3,
  parameter int W            = 32,
  parameter int RES_W        = 32,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_i,
  input  logic             y_vld_i,
  input  logic [W/2-1:0]   y_i,
  output logic             res_vld_o,
  output logic [RES_W-1:0] res_o,
  output logic             err_orphan_o
);

  localparam int POS_W = idx_width(N_ARGS);
  localparam int CNT_W = cnt_width(MAX_INFLIGHT);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_ARGS - 1);

  logic [CNT_W-1:0] out_q, out_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic             err_q, err_d;
  logic             w_take;
  logic [RES_W-1:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      pos_q     <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      pos_q     <= pos_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    // A result with nothing outstanding is an orphan: flagged, never summed.
    w_take    = y_vld_i && (out_q != '0);
    w_sum     = acc_q + RES_W'(y_i);
    out_d     = out_q;
    pos_d     = pos_q;
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    err_d     = err_q | (y_vld_i && (out_q == '0));

    if (issue_i && !w_take) begin
      out_d = out_q + CNT_W'(1);
    end else if (!issue_i && w_take) begin
      out_d = out_q - CNT_W'(1);
    end

    if (w_take) begin
      if (pos_q == LAST_POS) begin
        res_d     = w_sum;
        res_vld_d = 1'b1;
        acc_d     = '0;
        pos_d     = '0;
      end else begin
        acc_d = w_sum;
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  assign res_vld_o    = res_vld_q;
  assign res_o        = res_q;
  assign err_orphan_o = err_q;

endmodule
`default_nettype wire

// File: rtl/formula_sum_isqrt_pipe_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// formula_sum_isqrt_pipe_fsm - issues N_ARGS operands to a pipelined isqrt
// and returns the sum of their roots.                            Rev 1.0
// ---------------------------------------------------------------------------
module formula_sum_isqrt_pipe_fsm
  import formula_sum_isqrt_pkg::*;
#(
  parameter int N_ARGS       = 3,
  parameter int W            = 32,
  parameter int RES_W        = 32,
  parameter int MAX_INFLIGHT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arg_vld,
  output logic                arg_rdy,
  input  logic [N_ARGS*W-1:0] args,
  output logic                res_vld,
  output logic [RES_W-1:0]    res,
  output logic                err_orphan,
  output logic                isqrt_x_vld,
  output logic [W-1:0]        isqrt_x,
  input  logic                isqrt_y_vld,
  input  logic [W/2-1:0]      isqrt_y
);

  localparam int IDX_W = idx_width(N_ARGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ARGS - 1);

  if (N_ARGS < 1 || N_ARGS > 8 || (W % 2) != 0 || !res_w_legal(RES_W, W, N_ARGS))
  begin : g_param_check
    $error("formula_sum_isqrt_pipe_fsm: illegal N_ARGS/W/RES_W combination");
  end

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_ARGS*W-1:0] ops_q, ops_d;
  logic [W-1:0]        x_q;
  logic                w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ops_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ops_q   <= ops_d;
      x_q     <= isqrt_x;
    end
  end

  // Pending operands sit in a shift register so the next one is always in the low slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ops_d   = ops_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          ops_d = args >> W;
          idx_d = IDX_W'(1);
          if (N_ARGS > 1) state_d = ISSUE;
        end
      end
      ISSUE: begin
        ops_d = ops_q >> W;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arg_rdy     = (state_q == IDLE);
    w_accept    = arg_vld && (state_q == IDLE);
    isqrt_x_vld = w_accept || (state_q == ISSUE);
    isqrt_x     = x_q;
    if (w_accept) begin
      isqrt_x = args[W-1:0];
    end else if (state_q == ISSUE) begin
      isqrt_x = ops_q[W-1:0];
    end
  end

  isqrt_result_accumulator #(
    .N_ARGS       (N_ARGS),
    .W            (W),
    .RES_W        (RES_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_acc (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (isqrt_x_vld),
    .y_vld_i      (isqrt_y_vld),
    .y_i          (isqrt_y),
    .res_vld_o    (res_vld),
    .res_o        (res),
    .err_orphan_o (err_orphan)
  );

endmodule
`default_nettype wire

// File: tb/tb_formula_sum_isqrt_pipe_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_formula_sum_isqrt_pipe_fsm - N_ARGS 3/1/8 instances, each driven by a
// behavioural isqrt pipeline of latency L.                       Rev 1.0
// ---------------------------------------------------------------------------
module tb_formula_sum_isqrt_pipe_fsm;

  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, irst3;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_f(input logic [31:0] x);
    logic [15:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = {16'd0, r | (16'd1 << b)};
      if (t * t <= x) r = t[15:0];
    end
    return r;
  endfunction

  // ---- N_ARGS = 3 instance (its isqrt model has its own reset) ----
  logic        vld3, rdy3, rv3, err3, xv3, yv3;
  logic [95:0] args3;
  logic [31:0] r3, x3;
  logic [15:0] y3;
  logic [L-1:0] p3v;
  logic [15:0]  p3d [L];

  formula_sum_isqrt_pipe_fsm #(.N_ARGS(3), .W(32), .RES_W(32), .MAX_INFLIGHT(64)) dut3 (
    .clk(clk), .rst(rst), .arg_vld(vld3), .arg_rdy(rdy3), .args(args3),
    .res_vld(rv3), .res(r3), .err_orphan(err3),
    .isqrt_x_vld(xv3), .isqrt_x(x3), .isqrt_y_vld(yv3), .isqrt_y(y3));

  always @(posedge clk) begin
    p3v    <= irst3 ? '0 : {p3v[L-2:0], xv3};
    p3d[0] <= isqrt_f(x3);
    for (int i = 1; i < L; i++) p3d[i] <= p3d[i-1];
  end
  assign yv3 = p3v[L-1];
  assign y3  = p3d[L-1];

  // ---- N_ARGS = 1 instance ----
  logic        vld1, rdy1, rv1, err1, xv1, yv1;
  logic [31:0] args1, r1, x1;
  logic [15:0] y1;
  logic [L-1:0] p1v;
  logic [15:0]  p1d [L];

  formula_sum_isqrt_pipe_fsm #(.N_ARGS(1), .W(32), .RES_W(32), .MAX_INFLIGHT(64)) dut1 (
    .clk(clk), .rst(rst), .arg_vld(vld1), .arg_rdy(rdy1), .args(args1),
    .res_vld(rv1), .res(r1), .err_orphan(err1),
    .isqrt_x_vld(xv1), .isqrt_x(x1), .isqrt_y_vld(yv1), .isqrt_y(y1));

  always @(posedge clk) begin
    p1v    <= rst ? '0 : {p1v[L-2:0], xv1};
    p1d[0] <= isqrt_f(x1);
    for (int i = 1; i < L; i++) p1d[i] <= p1d[i-1];
  end
  assign yv1 = p1v[L-1];
  assign y1  = p1d[L-1];

  // ---- N_ARGS = 8 instance ----
  logic         vld8, rdy8, rv8, err8, xv8, yv8;
  logic [255:0] args8;
  logic [31:0]  r8, x8;
  logic [15:0]  y8;
  logic [L-1:0] p8v;
  logic [15:0]  p8d [L];

  formula_sum_isqrt_pipe_fsm #(.N_ARGS(8), .W(32), .RES_W(32), .MAX_INFLIGHT(64)) dut8 (
    .clk(clk), .rst(rst), .arg_vld(vld8), .arg_rdy(rdy8), .args(args8),
    .res_vld(rv8), .res(r8), .err_orphan(err8),
    .isqrt_x_vld(xv8), .isqrt_x(x8), .isqrt_y_vld(yv8), .isqrt_y(y8));

  always @(posedge clk) begin
    p8v    <= rst ? '0 : {p8v[L-2:0], xv8};
    p8d[0] <= isqrt_f(x8);
    for (int i = 1; i < L; i++) p8d[i] <= p8d[i-1];
  end
  assign yv8 = p8v[L-1];
  assign y8  = p8d[L-1];

  // ---- monitors: value and cycle of every issue (dut3) and result ----
  logic [31:0] iss_v[$], iss_c[$], r3_v[$], r3_c[$], r1_v[$], r1_c[$], r8_v[$], r8_c[$];

  always @(negedge clk) begin
    #2;
    if (xv3) begin iss_v.push_back(x3); iss_c.push_back(32'(cyc)); end
    if (rv3) begin r3_v.push_back(r3);  r3_c.push_back(32'(cyc)); end
    if (rv1) begin r1_v.push_back(r1);  r1_c.push_back(32'(cyc)); end
    if (rv8) begin r8_v.push_back(r8);  r8_c.push_back(32'(cyc)); end
  end

  task automatic clear_q();
    iss_v.delete(); iss_c.delete();
    r3_v.delete();  r3_c.delete();
    r1_v.delete();  r1_c.delete();
    r8_v.delete();  r8_c.delete();
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int qsize(input int which);
    case (which)
      1:       return r1_v.size();
      8:       return r8_v.size();
      default: return r3_v.size();
    endcase
  endfunction

  task automatic wait_res(input string tag, input int which, input int n);
    int k;
    k = 0;
    while (qsize(which) < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_arrived"}, 32'(qsize(which) >= n), 32'd1);
    repeat (L + 4) @(negedge clk);
    check_eq({tag, "_count"}, 32'(qsize(which)), 32'(n));
  endtask

  // Holds a batch on the N_ARGS=3 instance until accepted; returns the accept cycle.
  task automatic send3(input logic [95:0] a, output int tacc);
    int n;
    n     = 0;
    args3 = a;
    vld3  = 1'b1;
    while (!rdy3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 32'(n < 20), 32'd1);
    tacc = cyc;
    @(negedge clk);
  endtask

  logic [31:0] exp_iss [9] = '{32'd1, 32'd1, 32'd1, 32'd100, 32'd49, 32'd0,
                               32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] exp_r2  [3] = '{32'd3, 32'd17, 32'd65535};
  logic [31:0] exp_r1  [3] = '{32'd5, 32'd6, 32'd0};

  initial begin
    int t;
    int ta [3];
    rst = 1'b1; irst3 = 1'b1;
    vld3 = 1'b0; args3 = '0;
    vld1 = 1'b0; args1 = '0;
    vld8 = 1'b0; args8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; irst3 = 1'b0;

    check_eq("rst_arg_rdy", 32'(rdy3), 32'd1);
    check_eq("rst_x_vld",   32'(xv3),  32'd0);
    check_eq("rst_x",       x3,        32'd0);
    check_eq("rst_res_vld", 32'(rv3),  32'd0);
    check_eq("rst_res",     r3,        32'd0);
    check_eq("rst_err",     32'(err3), 32'd0);

    // single batch {16, 9, 4}
    clear_q();
    send3({32'd4, 32'd9, 32'd16}, t);
    vld3 = 1'b0;
    check_eq("t1_busy_rdy", 32'(rdy3), 32'd0);
    wait_res("t1_res", 3, 1);
    check_eq("t1_iss_n", 32'(iss_v.size()), 32'd3);
    check_eq("t1_iss0", at(iss_v, 0), 32'd16);
    check_eq("t1_iss1", at(iss_v, 1), 32'd9);
    check_eq("t1_iss2", at(iss_v, 2), 32'd4);
    check_eq("t1_iss0_cyc", at(iss_c, 0), 32'(t));
    check_eq("t1_iss2_cyc", at(iss_c, 2), 32'(t + 2));
    check_eq("t1_res_val", at(r3_v, 0), 32'd9);
    check_eq("t1_res_cyc", at(r3_c, 0), 32'(t + 3 + L));

    // back-to-back with arg_vld held high; new batch presented while busy
    clear_q();
    send3({32'd1, 32'd1, 32'd1}, ta[0]);
    check_eq("t2_rdy_in_issue", 32'(rdy3), 32'd0);
    send3({32'd0, 32'd49, 32'd100}, ta[1]);
    send3({32'd0, 32'd0, 32'hFFFF_FFFF}, ta[2]);
    vld3 = 1'b0;
    check_eq("t2_gap01", 32'(ta[1] - ta[0]), 32'd3);
    check_eq("t2_gap12", 32'(ta[2] - ta[1]), 32'd3);
    wait_res("t2_res", 3, 3);
    check_eq("t2_iss_n", 32'(iss_v.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      check_eq($sformatf("t2_iss%0d", i), at(iss_v, i), exp_iss[i]);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t2_res%0d", i), at(r3_v, i), exp_r2[i]);
      check_eq($sformatf("t2_res%0d_cyc", i), at(r3_c, i), 32'(ta[i] + 3 + L));
    end

    // N_ARGS = 1: accept every cycle
    clear_q();
    args1 = 32'd25; vld1 = 1'b1; t = cyc;
    check_eq("t3_rdy0", 32'(rdy1), 32'd1);
    @(negedge clk);
    args1 = 32'd36;
    check_eq("t3_rdy1", 32'(rdy1), 32'd1);
    @(negedge clk);
    args1 = 32'd0;
    check_eq("t3_rdy2", 32'(rdy1), 32'd1);
    @(negedge clk);
    vld1 = 1'b0;
    wait_res("t3_res", 1, 3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_res%0d", i), at(r1_v, i), exp_r1[i]);
      check_eq($sformatf("t3_res%0d_cyc", i), at(r1_c, i), 32'(t + i + 1 + L));
    end

    // N_ARGS = 8, all operands at maximum
    clear_q();
    args8 = '1; vld8 = 1'b1; t = cyc;
    check_eq("t4_rdy", 32'(rdy8), 32'd1);
    @(negedge clk);
    vld8 = 1'b0;
    wait_res("t4_res", 8, 1);
    check_eq("t4_res_val", at(r8_v, 0), 32'd524280);
    check_eq("t4_res_cyc", at(r8_c, 0), 32'(t + 8 + L));
    check_eq("t4_err", 32'(err8), 32'd0);

    // reset after the second issue; isqrt model keeps its in-flight results
    clear_q();
    args3 = {32'd4, 32'd9, 32'd16}; vld3 = 1'b1;
    @(negedge clk);
    vld3 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_rdy_after_rst", 32'(rdy3), 32'd1);
    check_eq("t5_xvld_after_rst", 32'(xv3), 32'd0);
    repeat (L + 4) @(negedge clk);
    check_eq("t5_iss_n", 32'(iss_v.size()), 32'd2);
    check_eq("t5_no_res", 32'(r3_v.size()), 32'd0);
    check_eq("t5_err_orphan", 32'(err3), 32'd1);
    send3({32'd4, 32'd4, 32'd4}, t);
    vld3 = 1'b0;
    wait_res("t5_res", 3, 1);
    check_eq("t5_res_val", at(r3_v, 0), 32'd6);
    check_eq("t5_res_cyc", at(r3_c, 0), 32'(t + 3 + L));
    check_eq("t5_err_sticky", 32'(err3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/formula_sum_isqrt_pipe_fsm.md
# formula_sum_isqrt_pipe_fsm

Parametrised FSM-plus-datapath that computes res = isqrt(x0) + isqrt(x1) + … + isqrt(x[N_ARGS-1]) using one external pipelined isqrt instance. The isqrt instance sits beside this block in a top-level wrapper. This block generalises the fixed three-operand formula controller in three ways: configurable operand count and width, a valid/ready input handshake, and tracking of in-flight isqrt operations. It accepts a new operand batch every N_ARGS cycles and does not depend on the isqrt latency value.

## Interface
- N_ARGS, default 3: operands per batch; legal range 1..8.
- W, default 32: operand width; must be even.
- RES_W, default 32: result width; must be ≥ W/2 + $clog2(N_ARGS) (elaboration-time check).
- MAX_INFLIGHT, default 64: upper bound on outstanding isqrt operations; must be ≥ isqrt latency + N_ARGS.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- arg_vld  in  1  batch valid.
- arg_rdy  out  1  batch accepted when arg_vld && arg_rdy.
- args  in  N_ARGS*W  packed operands; operand i is args[i*W +: W].
- res_vld  out  1  one-cycle result strobe.
- res  out  RES_W  sum of square roots, zero-extended.
- err_orphan  out  1  sticky; set when an unexpected isqrt result arrives.
- isqrt_x_vld  out  1  issue strobe to isqrt.
- isqrt_x  out  W  operand to isqrt.
- isqrt_y_vld  in  1  result strobe from isqrt.
- isqrt_y  in  W/2  isqrt result.

## Operation
- States: IDLE, ISSUE.
- arg_rdy = (state == IDLE).
- IDLE, on accept:
  - isqrt_x = operand 0 and isqrt_x_vld = 1 in the same cycle.
  - Operands 1..N_ARGS-1 are registered.
  - Issue index set to 1.
  - Go to ISSUE if N_ARGS > 1; otherwise stay in IDLE.
- IDLE, no accept: isqrt_x_vld = 0. isqrt_x holds its last value; its content is don't-care.
- ISSUE:
  - Each cycle: isqrt_x = the registered operand at the current index, isqrt_x_vld = 1, index increments.
  - After issuing index N_ARGS-1, go to IDLE.
  - No stalls: the isqrt pipeline is always ready.
- Outstanding counter ($clog2(MAX_INFLIGHT+1) bits):
  - +1 per issue, −1 per isqrt_y_vld.
  - Issue and return in the same cycle leave it unchanged.
- Accumulator:
  - On isqrt_y_vld with outstanding > 0: acc += zero-extended isqrt_y, and the result-position counter (0..N_ARGS-1) increments.
  - At position N_ARGS-1: register res = acc + isqrt_y, pulse res_vld, clear acc and position to 0.
  - Results return in issue order, so batches never interleave in the accumulator.
- Orphan results: isqrt_y_vld with outstanding == 0 is dropped (no accumulation) and sets err_orphan. err_orphan clears only on rst.
- Arithmetic: unsigned throughout; no overflow is possible given the RES_W rule.

## Timing
- Batch accepted at cycle t: operand i is issued at cycle t+i.
- Nth isqrt result arrives at t+N_ARGS-1+L, where L is the isqrt latency.
- res_vld rises at t+N_ARGS+L (registered output).
- Throughput: one batch per N_ARGS cycles. The earliest next accept is t+N_ARGS; for N_ARGS=1, every cycle.
- Reset values: state IDLE, arg_rdy=1, isqrt_x_vld=0, isqrt_x=0, res_vld=0, res=0, err_orphan=0, acc, position and outstanding all 0.
- Reset mid-batch:
  - Pending issues are abandoned and the partial sum is discarded.
  - Results still in the isqrt pipeline after rst arrive with outstanding==0. They are dropped and set err_orphan. A bench must reset isqrt together with this block, or expect the flag.
- arg_vld while arg_rdy=0 is ignored; the source must hold the batch.

## Structure
- Package formula_sum_isqrt_pkg holds:
  - the state enum (IDLE, ISSUE);
  - localparam functions for the index width ($clog2(N_ARGS)) and counter width;
  - the RES_W legality function used by the elaboration check.
- One sub-module: isqrt_result_accumulator. It owns the outstanding counter, position counter, acc/res registers and err_orphan. Its inputs are the issue strobe and the isqrt_y_vld/isqrt_y pair.
- Top-level test wrapper formula_sum_isqrt_pipe_fsm_top instantiates this block and one isqrt.

## Test plan
- N_ARGS=3, W=32: single batch {16, 9, 4} -> issues 16, 9, 4 on consecutive cycles; res=9 with res_vld at t+3+L.
- Back-to-back: arg_vld held high with batches {1,1,1}, {100,49,0}, {0xFFFFFFFF,0,0} -> accepts every 3 cycles; results 3, 17, 65535, in order with no gaps between strobes.
- N_ARGS=1: accept every cycle with {25}, {36}, {0} -> res 5, 6, 0 on consecutive cycles.
- N_ARGS=8, max operands 0xFFFFFFFF -> res = 8*65535 = 524280; no truncation.
- Reset after the second issue of {16,9,4} with isqrt not reset -> no res_vld; err_orphan=1 after the stale results drain; the next batch {4,4,4} gives res=6.
- arg_vld asserted during ISSUE -> arg_rdy=0, batch not captured until IDLE; the issue order of the current batch is unchanged.
